// File: rtl/threshold_edit_ctrl.sv
// Front-panel setpoint editor: debounced keys drive an IDLE/EDIT machine that
// edits a 3-digit BCD working copy and commits it to the alarm threshold.
module threshold_edit_ctrl #(
    parameter int DEB_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int BLINK_HALF     = 250,
    parameter int INIT_WARN      = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_sel_in,
    input  logic        key_inc_in,
    input  logic        key_mode_in,
    output logic [11:0] data_warn,
    output logic [11:0] edit_data,
    output logic        show_flag,
    output logic [1:0]  flash_flag,
    output logic        blink,
    output logic        commit_pulse
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(BLINK_HALF - 1);
    localparam logic [11:0]   INIT_BCD = {4'(INIT_WARN / 100), 4'((INIT_WARN / 10) % 10),
                                          4'(INIT_WARN % 10)};
    localparam logic [11:0]   INIT_BIN = 12'(INIT_WARN);

    typedef enum logic {S_IDLE, S_EDIT} state_t;

    // Key index: 0 = sel, 1 = inc, 2 = mode
    logic [2:0] w_key_raw;
    logic [2:0] w_press;
    assign w_key_raw = {key_mode_in, key_inc_in, key_sel_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_key
            logic          r_meta, r_sync, r_stable, r_stable_d, r_press;
            logic [DW-1:0] r_deb_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_meta     <= 1'b0;
                    r_sync     <= 1'b0;
                    r_stable   <= 1'b0;
                    r_stable_d <= 1'b0;
                    r_press    <= 1'b0;
                    r_deb_cnt  <= '0;
                end else begin
                    r_meta     <= w_key_raw[gi];
                    r_sync     <= r_meta;
                    r_stable_d <= r_stable;
                    r_press    <= r_stable & ~r_stable_d;
                    // The new level is accepted only after DEB_CYCLES+1 differing samples
                    if (r_sync == r_stable) begin
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt == DEB_MAX) begin
                        r_stable  <= r_sync;
                        r_deb_cnt <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    logic w_ev_mode, w_ev_sel, w_ev_inc, w_any_event;
    assign w_ev_mode   = w_press[2];
    assign w_ev_sel    = w_press[0] & ~w_press[2];
    assign w_ev_inc    = w_press[1] & ~w_press[0] & ~w_press[2];
    assign w_any_event = |w_press;

    state_t        r_state, w_state_next;
    logic [11:0]   r_warn_bcd, r_edit_bcd, w_warn_bcd_next, w_edit_bcd_next;
    logic [TW-1:0] r_timer, w_timer_next;
    logic [BW-1:0] r_bcnt, w_bcnt_next;
    logic [1:0]    w_flash_next;
    logic          w_blink_next, w_commit_next, w_expire;
    logic [3:0]    w_digit, w_digit_inc;

    function automatic logic [11:0] bcd2bin(input logic [11:0] b);
        return 12'(b[11:8]) * 12'd100 + 12'(b[7:4]) * 12'd10 + 12'(b[3:0]);
    endfunction

    assign w_expire    = (r_timer == T_LAST) && !w_any_event;
    assign w_digit     = r_edit_bcd[{flash_flag, 2'b00} +: 4];
    assign w_digit_inc = (w_digit == 4'd9) ? 4'd0 : w_digit + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_ev_mode) w_state_next = S_EDIT;
            S_EDIT:  if (w_ev_mode || w_expire) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_warn_bcd_next = r_warn_bcd;
        w_edit_bcd_next = r_edit_bcd;
        w_timer_next    = r_timer;
        w_bcnt_next     = r_bcnt;
        w_flash_next    = flash_flag;
        w_blink_next    = blink;
        w_commit_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ev_mode) begin
                    w_edit_bcd_next = r_warn_bcd;
                    w_flash_next    = 2'd0;
                    w_timer_next    = '0;
                    w_bcnt_next     = '0;
                    w_blink_next    = 1'b1;
                end
            end
            S_EDIT: begin
                if (r_bcnt == B_LAST) begin
                    w_bcnt_next  = '0;
                    w_blink_next = ~blink;
                end else begin
                    w_bcnt_next = r_bcnt + 1'b1;
                end
                if (w_ev_mode) begin
                    w_warn_bcd_next = r_edit_bcd;
                    w_commit_next   = 1'b1;
                    w_flash_next    = 2'd0;
                    w_blink_next    = 1'b0;
                end else if (w_ev_sel) begin
                    w_flash_next = (flash_flag == 2'd2) ? 2'd0 : flash_flag + 2'd1;
                    w_timer_next = '0;
                end else if (w_ev_inc) begin
                    // Digits wrap independently; no carry into the neighbour
                    w_edit_bcd_next[{flash_flag, 2'b00} +: 4] = w_digit_inc;
                    w_timer_next = '0;
                end else if (w_expire) begin
                    w_edit_bcd_next = r_warn_bcd;
                    w_flash_next    = 2'd0;
                    w_blink_next    = 1'b0;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_warn_bcd   <= INIT_BCD;
            r_edit_bcd   <= INIT_BCD;
            r_timer      <= '0;
            r_bcnt       <= '0;
            data_warn    <= INIT_BIN;
            edit_data    <= INIT_BIN;
            show_flag    <= 1'b0;
            flash_flag   <= 2'd0;
            blink        <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            r_warn_bcd   <= w_warn_bcd_next;
            r_edit_bcd   <= w_edit_bcd_next;
            r_timer      <= w_timer_next;
            r_bcnt       <= w_bcnt_next;
            data_warn    <= bcd2bin(w_warn_bcd_next);
            edit_data    <= bcd2bin(w_edit_bcd_next);
            show_flag    <= (w_state_next == S_EDIT);
            flash_flag   <= w_flash_next;
            blink        <= w_blink_next;
            commit_pulse <= w_commit_next;
        end
    end

endmodule

// File: tb/tb_threshold_edit_ctrl.sv
// Directed bench for threshold_edit_ctrl: table of key presses with expected
// outputs, plus hand-written latency, blink, timeout, glitch and reset sequences.
module tb_threshold_edit_ctrl;

    localparam int DEB  = 4;
    localparam int TOUT = 60;
    localparam int BH   = 5;
    localparam int INIT = 200;

    localparam int OP_SEL  = 1;
    localparam int OP_INC  = 2;
    localparam int OP_MODE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_sel_in = 1'b0, key_inc_in = 1'b0, key_mode_in = 1'b0;
    logic [11:0] data_warn, edit_data;
    logic        show_flag, blink, commit_pulse;
    logic [1:0]  flash_flag;

    int checks = 0;
    int errors = 0;
    int n_commit = 0;
    logic [11:0] prev_warn = 12'(INIT);

    threshold_edit_ctrl #(
        .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TOUT), .BLINK_HALF(BH), .INIT_WARN(INIT)
    ) dut (
        .clk(clk), .rst(rst),
        .key_sel_in(key_sel_in), .key_inc_in(key_inc_in), .key_mode_in(key_mode_in),
        .data_warn(data_warn), .edit_data(edit_data), .show_flag(show_flag),
        .flash_flag(flash_flag), .blink(blink), .commit_pulse(commit_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // data_warn may only move together with commit_pulse
    always @(negedge clk) begin
        if (rst) begin
            prev_warn = data_warn;
        end else begin
            if (commit_pulse) n_commit++;
            if (data_warn !== prev_warn) begin
                checks++;
                if (commit_pulse !== 1'b1) begin
                    errors++;
                    $display("FAIL warn_change_without_commit: got commit_pulse=%0b required 1", commit_pulse);
                end
                $display("data_warn %0d -> %0d", prev_warn, data_warn);
            end
            prev_warn = data_warn;
        end
    end

    task automatic set_key(input int op, input logic v);
        case (op)
            OP_SEL:  key_sel_in  = v;
            OP_INC:  key_inc_in  = v;
            OP_MODE: key_mode_in = v;
            default: ;
        endcase
    endtask

    // Returns just after the edge at which the press takes effect, key released
    task automatic press(input int op);
        @(negedge clk);
        set_key(op, 1'b1);
        repeat (DEB + 5) @(posedge clk);
        #1;
        set_key(op, 1'b0);
    endtask

    typedef struct {
        int op; int edit; int warn; int show; int flash; int commits;
    } vec_t;
    vec_t tbl[$];

    typedef struct { logic lvl; int cyc; } bounce_t;
    bounce_t bounce[$];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // --- stimulus table ---
        tbl.push_back('{OP_MODE, 200, 200, 1, 0, 0});
        for (int k = 1; k <= 9; k++) tbl.push_back('{OP_INC, 200 + k, 200, 1, 0, 0});
        tbl.push_back('{OP_INC,  200, 200, 1, 0, 0});
        tbl.push_back('{OP_MODE, 200, 200, 0, 0, 1});
        tbl.push_back('{OP_MODE, 200, 200, 1, 0, 1});
        tbl.push_back('{OP_SEL,  200, 200, 1, 1, 1});
        for (int k = 1; k <= 3; k++) tbl.push_back('{OP_INC, 200 + 10 * k, 200, 1, 1, 1});
        tbl.push_back('{OP_SEL,  230, 200, 1, 2, 1});
        for (int k = 3; k <= 9; k++) tbl.push_back('{OP_INC, 100 * k + 30, 200, 1, 2, 1});
        tbl.push_back('{OP_INC,  30,  200, 1, 2, 1});
        tbl.push_back('{OP_MODE, 30,  30,  0, 0, 2});
        tbl.push_back('{OP_MODE, 30,  30,  1, 0, 2});
        tbl.push_back('{OP_SEL,  30,  30,  1, 1, 2});
        tbl.push_back('{OP_SEL,  30,  30,  1, 2, 2});
        tbl.push_back('{OP_SEL,  30,  30,  1, 0, 2});
        tbl.push_back('{OP_INC,  31,  30,  1, 0, 2});
        tbl.push_back('{OP_MODE, 31,  31,  0, 0, 3});
        tbl.push_back('{OP_INC,  31,  31,  0, 0, 3});
        tbl.push_back('{OP_SEL,  31,  31,  0, 0, 3});

        // --- reset and idle ---
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_warn", data_warn, 200);
        chk("idle_edit", edit_data, 200);
        chk("idle_show", show_flag, 0);
        chk("idle_flash", flash_flag, 0);
        chk("idle_blink", blink, 0);
        chk("idle_commits", n_commit, 0);

        // --- table-driven presses ---
        foreach (tbl[i]) begin
            press(tbl[i].op);
            repeat (DEB + 6) @(posedge clk);
            #1;
            $display("vec %0d op=%0d edit=%0d warn=%0d show=%0b flash=%0d commits=%0d",
                     i, tbl[i].op, edit_data, data_warn, show_flag, flash_flag, n_commit);
            chk("tbl_edit", edit_data, tbl[i].edit);
            chk("tbl_warn", data_warn, tbl[i].warn);
            chk("tbl_show", show_flag, tbl[i].show);
            chk("tbl_flash", flash_flag, tbl[i].flash);
            chk("tbl_commits", n_commit, tbl[i].commits);
            if (tbl[i].show == 0) chk("tbl_blink_idle", blink, 0);
        end

        // --- exact latency, blink phase, held key, timeout ---
        @(negedge clk) key_mode_in = 1'b1;
        repeat (DEB + 4) @(posedge clk);
        #1 chk("latency_early", show_flag, 0);
        @(posedge clk);
        #1 chk("latency_edge", show_flag, 1);
        chk("blink_entry", blink, 1);
        repeat (BH - 1) @(posedge clk);
        #1 chk("blink_hold", blink, 1);
        @(posedge clk);
        #1 chk("blink_toggle", blink, 0);
        repeat (15) @(posedge clk);
        #1 chk("held_no_repeat_show", show_flag, 1);
        chk("held_no_repeat_commits", n_commit, 3);
        key_mode_in = 1'b0;
        repeat (DEB + 6) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            press(OP_INC);
            $display("timeout-seq inc %0d edit=%0d", k, edit_data);
            if (k < 3) repeat (DEB + 6) @(posedge clk);
        end
        chk("pre_timeout_edit", edit_data, 35);
        repeat (TOUT - 1) @(posedge clk);
        #1 chk("timeout_early", show_flag, 1);
        @(posedge clk);
        #1 chk("timeout_show", show_flag, 0);
        chk("timeout_edit", edit_data, 31);
        chk("timeout_warn", data_warn, 31);
        chk("timeout_flash", flash_flag, 0);
        chk("timeout_blink", blink, 0);
        chk("timeout_commits", n_commit, 3);

        // --- glitch shorter than the debounce window ---
        repeat (DEB + 6) @(posedge clk);
        @(negedge clk) key_mode_in = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        key_mode_in = 1'b0;
        repeat (3 * DEB + 6) @(posedge clk);
        #1 chk("glitch_ignored", show_flag, 0);

        // --- bounce train ending in a stable press ---
        bounce.push_back('{1'b1, 2});
        bounce.push_back('{1'b0, 1});
        bounce.push_back('{1'b1, 3});
        bounce.push_back('{1'b0, 2});
        bounce.push_back('{1'b1, 1});
        bounce.push_back('{1'b0, 2});
        foreach (bounce[i]) begin
            @(negedge clk) key_mode_in = bounce[i].lvl;
            repeat (bounce[i].cyc - 1) @(negedge clk);
        end
        @(negedge clk) key_mode_in = 1'b1;
        repeat (DEB + 4) @(posedge clk);
        #1 chk("bounce_early", show_flag, 0);
        @(posedge clk);
        #1 chk("bounce_event", show_flag, 1);
        repeat (20) @(posedge clk);
        #1 chk("bounce_single", show_flag, 1);
        key_mode_in = 1'b0;
        repeat (DEB + 6) @(posedge clk);
        press(OP_MODE);
        repeat (DEB + 6) @(posedge clk);
        #1 chk("bounce_commit_show", show_flag, 0);
        chk("bounce_commit_count", n_commit, 4);
        chk("bounce_commit_warn", data_warn, 31);

        // --- mode and sel in the same cycle: mode wins ---
        @(negedge clk);
        key_mode_in = 1'b1;
        key_sel_in  = 1'b1;
        repeat (DEB + 5) @(posedge clk);
        #1 chk("simul_show", show_flag, 1);
        chk("simul_flash", flash_flag, 0);
        key_mode_in = 1'b0;
        key_sel_in  = 1'b0;
        repeat (DEB + 6) @(posedge clk);
        #1 chk("simul_flash_after", flash_flag, 0);
        press(OP_INC);
        repeat (DEB + 6) @(posedge clk);
        #1 chk("pre_reset_edit", edit_data, 32);

        // --- asynchronous reset mid-EDIT ---
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_warn", data_warn, 200);
        chk("rst_edit", edit_data, 200);
        chk("rst_show", show_flag, 0);
        chk("rst_flash", flash_flag, 0);
        chk("rst_blink", blink, 0);
        chk("rst_commit", commit_pulse, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("post_rst_show", show_flag, 0);
        chk("post_rst_warn", data_warn, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
